// File: rtl/alu_r32im_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_r32im_pkg
//  Brief    : Operation codes and width constant shared by the RV32IM ALU
//             and the instruction decoder.
//  Revision : 1.0
// ============================================================================
package alu_r32im_pkg;

    localparam int c_data_w = 32;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_CPY    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_r32im_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : alu_r32im_muldiv
//  Brief    : Combinational M-extension unit: multiply high/low, divide and
//             remainder with RISC-V divide-by-zero and overflow results.
//  Revision : 1.0
// ============================================================================
module alu_r32im_muldiv
    import alu_r32im_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_e     i_op,
    output logic [31:0] o_result
);

    logic        w_mul_a_sgn;
    logic        w_mul_b_sgn;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;

    // One 64-bit product serves all four multiplies; extension selects signedness.
    assign w_mul_a_sgn = (i_op == ALU_MULH) || (i_op == ALU_MULHSU);
    assign w_mul_b_sgn = (i_op == ALU_MULH);
    assign w_a64       = {{32{w_mul_a_sgn & i_a[31]}}, i_a};
    assign w_b64       = {{32{w_mul_b_sgn & i_b[31]}}, i_b};
    assign w_prod      = w_a64 * w_b64;

    logic        w_div_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_ub_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Signed division on magnitudes; the overflow case falls out naturally.
    assign w_div_sgn = (i_op == ALU_DIV) || (i_op == ALU_REM);
    assign w_a_neg   = w_div_sgn & i_a[31];
    assign w_b_neg   = w_div_sgn & i_b[31];
    assign w_b_zero  = (i_b == 32'd0);
    assign w_ua      = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_ub      = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_ub_safe = w_b_zero ? 32'd1 : w_ub;
    assign w_q_mag   = w_ua / w_ub_safe;
    assign w_r_mag   = w_ua % w_ub_safe;
    assign w_q       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r       = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_result = 32'd0;
        case (i_op)
            ALU_MUL:    o_result = w_prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  o_result = w_prod[63:32];
            ALU_DIV,
            ALU_DIVU:   o_result = w_b_zero ? 32'hFFFF_FFFF : w_q;
            ALU_REM,
            ALU_REMU:   o_result = w_b_zero ? i_a : w_r;
            default:    o_result = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_r32im.sv
`default_nettype none
// ============================================================================
//  Module   : alu_r32im
//  Brief    : RV32IM execute-stage ALU, base and M-extension ops, one-cycle
//             registered result.
//  Revision : 1.0
// ============================================================================
module alu_r32im
    import alu_r32im_pkg::*;
#(
    parameter int dataW = c_data_w
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    input  logic [4:0]       ALUCode,
    output logic [dataW-1:0] result
);

    alu_op_e          w_op;
    logic [4:0]       w_shamt;
    logic [dataW-1:0] w_md_result;
    logic [dataW-1:0] w_next;
    logic [dataW-1:0] r_result;

    assign w_op    = alu_op_e'(ALUCode);
    assign w_shamt = B[4:0];

    alu_r32im_muldiv u_muldiv (
        .i_a      (A),
        .i_b      (B),
        .i_op     (w_op),
        .o_result (w_md_result)
    );

    always_comb begin
        w_next = '0;
        case (w_op)
            ALU_ADD:    w_next = A + B;
            ALU_SUB:    w_next = A - B;
            ALU_SLL:    w_next = A << w_shamt;
            ALU_SLT:    w_next = {{(dataW-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU:   w_next = {{(dataW-1){1'b0}}, (A < B)};
            ALU_XOR:    w_next = A ^ B;
            ALU_SRL:    w_next = A >> w_shamt;
            ALU_SRA:    w_next = $unsigned($signed(A) >>> w_shamt);
            ALU_OR:     w_next = A | B;
            ALU_AND:    w_next = A & B;
            ALU_CPY:    w_next = B;
            ALU_MUL,
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU,
            ALU_DIV,
            ALU_DIVU,
            ALU_REM,
            ALU_REMU:   w_next = w_md_result;
            default:    w_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
        end else begin
            r_result <= w_next;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_r32im.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_r32im
//  Brief    : Self-checking bench for alu_r32im: directed vectors plus
//             randomized back-to-back ops against an arithmetic model.
//  Revision : 1.0
// ============================================================================
module tb_alu_r32im;
    import alu_r32im_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ALUCode;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    alu_r32im #(.dataW(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .ALUCode (ALUCode),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference behaviour written directly from the ISA definitions.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b & 32'd31);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << sh;
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> sh;
            5'd7:  begin p = 64'(sa >>> sh); return p[31:0]; end
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd11: begin p = 64'(sa * sb); return p[31:0]; end
            5'd12: begin p = 64'(sa * sb); return p[63:32]; end
            5'd13: begin p = 64'(sa * ub); return p[63:32]; end
            5'd14: begin p = 64'(ua * ub); return p[63:32]; end
            5'd15: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(sa / sb);
                return p[31:0];
            end
            5'd16: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            5'd17: begin
                if (b == 0) return a;
                p = 64'(sa % sb);
                return p[31:0];
            end
            5'd18: return (b == 0) ? a : 32'(ua % ub);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] special [8];
        special = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                    32'd2, 32'hFFFF_FFFE, 32'd31};
        if ($urandom_range(3) == 0) return special[$urandom_range(7)];
        return $urandom;
    endfunction

    task automatic test_reset();
        reset = 1'b1; A = 32'hDEAD_BEEF; B = 32'h1234_5678; ALUCode = 5'd0;
        @(posedge clock); #1;
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", result, 32'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{ALU_ADD,    32'd9,          32'd4,          32'd13});
        v.push_back('{ALU_SUB,    32'd9,          32'd10,         32'hFFFF_FFFF});
        v.push_back('{ALU_SUB,    -32'sd78,       -32'sd901,      32'd823});
        v.push_back('{ALU_SLT,    32'd9,          32'd4,          32'd0});
        v.push_back('{ALU_SLT,    32'd2,          32'd4,          32'd1});
        v.push_back('{ALU_SLTU,   32'd9,          32'd4,          32'd0});
        v.push_back('{ALU_SLTU,   -32'sd2,        32'd4,          32'd0});
        v.push_back('{ALU_SLTU,   -32'sd2,        -32'sd1,        32'd1});
        v.push_back('{ALU_AND,    32'd9,          32'd5,          32'd1});
        v.push_back('{ALU_OR,     32'd9,          32'd5,          32'd13});
        v.push_back('{ALU_XOR,    32'd9,          32'd5,          32'd12});
        v.push_back('{ALU_SLL,    32'd9,          32'd1,          32'd18});
        v.push_back('{ALU_SRL,    32'd9,          32'd3,          32'd1});
        v.push_back('{ALU_SRA,    32'd9,          32'd3,          32'd1});
        v.push_back('{ALU_SRA,    -32'sd9,        32'd3,          32'hFFFF_FFFE});
        v.push_back('{ALU_SRL,    -32'sd9,        32'd3,          32'h1FFF_FFFE});
        v.push_back('{ALU_CPY,    -32'sd9,        32'd3,          32'd3});
        v.push_back('{ALU_SLL,    32'd1,          32'h21,         32'd2});
        v.push_back('{ALU_MUL,    32'h0001_4C83,  32'hFFFE_8BB0,  32'h1C69_BB10});
        v.push_back('{ALU_MULH,   32'h0001_4C83,  32'hFFFE_8BB0,  32'hFFFF_FFFE});
        v.push_back('{ALU_MULHU,  32'h0001_4C83,  32'hFFFE_8BB0,  32'h0001_4C81});
        v.push_back('{ALU_MULHSU, 32'h0001_4C83,  32'hFFFE_8BB0,  32'h0001_4C81});
        v.push_back('{ALU_MULHSU, 32'hFFFE_B37D,  32'hFFFE_8BB0,  32'hFFFE_B37E});
        v.push_back('{ALU_DIV,    32'd18,         32'd4,          32'd4});
        v.push_back('{ALU_REM,    32'd18,         32'd4,          32'd2});
        v.push_back('{ALU_DIV,    32'd18,         -32'sd4,        32'hFFFF_FFFC});
        v.push_back('{ALU_REM,    32'd18,         -32'sd4,        32'd2});
        v.push_back('{ALU_DIVU,   32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF});
        v.push_back('{ALU_DIV,    32'd18,         32'd0,          32'hFFFF_FFFF});
        v.push_back('{ALU_DIVU,   32'd18,         32'd0,          32'hFFFF_FFFF});
        v.push_back('{ALU_REM,    32'd18,         32'd0,          32'd18});
        v.push_back('{ALU_REMU,   32'd18,         32'd0,          32'd18});
        v.push_back('{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
        v.push_back('{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
        v.push_back('{5'd25,      32'h1234_5678,  32'h9ABC_DEF0,  32'd0});
        foreach (v[i]) begin
            A = v[i].a; B = v[i].b; ALUCode = v[i].op;
            @(posedge clock); #1;
            checks++;
            if (result !== v[i].exp) begin
                failures++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h got=%h exp=%h",
                         i, v[i].op, v[i].a, v[i].b, result, v[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int n = 0; n < 400; n++) begin
            A = pick_operand();
            B = pick_operand();
            ALUCode = 5'($urandom_range(31));
            exp = model(ALUCode, A, B);
            @(posedge clock); #1;
            checks++;
            if (result !== exp) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h exp=%h",
                         n, ALUCode, A, B, result, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        A = 32'd100; B = 32'd23; ALUCode = ALU_ADD;
        @(posedge clock); #1;
        checks++;
        if (result !== 32'd123) begin
            failures++;
            $display("FAIL pre_reset_add got=%h exp=%h", result, 32'd123);
        end
        reset = 1'b1; ALUCode = ALU_SUB;
        @(posedge clock); #1;
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", result, 32'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (result !== 32'd77) begin
            failures++;
            $display("FAIL post_reset_sub got=%h exp=%h", result, 32'd77);
        end
    endtask

    initial begin
        reset = 1'b0; A = '0; B = '0; ALUCode = '0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
